// File: rtl/pong_pkg.sv
// Shared encodings for the pong screen sequencer: screen modes, menu/options
// item indices and the power-on ball speed.
package pong_pkg;

  typedef enum logic [2:0] {
    SCR_MENU    = 3'b000,
    SCR_GAME    = 3'b001,
    SCR_CREDITS = 3'b010,
    SCR_OPTIONS = 3'b011,
    SCR_P1WIN   = 3'b100,
    SCR_P2WIN   = 3'b101
  } screen_t;

  localparam logic [1:0] MENU_PLAY     = 2'd0;
  localparam logic [1:0] MENU_OPTIONS  = 2'd1;
  localparam logic [1:0] MENU_CREDITS  = 2'd2;

  localparam logic [1:0] OPT_SPEED     = 2'd0;
  localparam logic [1:0] OPT_BACK      = 2'd1;

  localparam logic [1:0] SPEED_DEFAULT = 2'd1;

endpackage

// File: rtl/button_debounce.sv
// Per-button debouncer: accepts a raw level once it has been stable for
// DEBOUNCE_CYCLES samples and emits a single press pulse on each acceptance of a high level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          raw_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_q <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      raw_q <= raw;
      press <= 1'b0;
      if (raw != raw_q) begin
        cnt <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end else begin
        // press is registered alongside level so it is high in the same cycle level first rises
        level <= raw;
        press <= raw & ~level;
      end
    end
  end

endmodule

// File: rtl/screen_controller.sv
// Game/menu sequencer ahead of the VGA stage: debounced buttons drive the
// screen FSM, options speed setting and the two-player score counters.
module screen_controller
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned WIN_SCORE       = 9,
  parameter int unsigned WIN_HOLD_CYCLES = 325000000
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       btn_back,
  input  logic       point_left,
  input  logic       point_right,
  output logic [2:0] screen_mode,
  output logic [1:0] icon_highlighter,
  output logic [1:0] speed_selector,
  output logic [7:0] score,
  output logic       game_active,
  output logic       serve
);

  localparam int unsigned HW = (WIN_HOLD_CYCLES > 1) ? $clog2(WIN_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(WIN_HOLD_CYCLES - 1);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

  // bit order: 0 select, 1 back, 2 up, 3 down
  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] press;

  assign raw = {btn_down, btn_up, btn_back, btn_select};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (pclk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  logic [3:0] hit;
  logic       do_sel, do_back, do_up, do_down;

  assign hit     = press & level;
  assign do_sel  = hit[0];
  assign do_back = hit[1] & ~hit[0];
  assign do_up   = hit[2] & ~hit[1] & ~hit[0];
  assign do_down = hit[3] & ~hit[2] & ~hit[1] & ~hit[0];

  screen_t       state, state_n;
  logic [1:0]    icon, icon_n;
  logic [1:0]    speed, speed_n;
  logic [3:0]    p1, p1_n, p2, p2_n;
  logic          serve_n;
  logic [HW-1:0] hold, hold_n;
  logic [3:0]    p1_sum, p2_sum;

  assign p1_sum = p1 + 4'(point_left);
  assign p2_sum = p2 + 4'(point_right);

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state <= SCR_MENU;
      icon  <= MENU_PLAY;
      speed <= SPEED_DEFAULT;
      p1    <= '0;
      p2    <= '0;
      serve <= 1'b0;
      hold  <= '0;
    end else begin
      state <= state_n;
      icon  <= icon_n;
      speed <= speed_n;
      p1    <= p1_n;
      p2    <= p2_n;
      serve <= serve_n;
      hold  <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    icon_n  = icon;
    speed_n = speed;
    p1_n    = p1;
    p2_n    = p2;
    serve_n = 1'b0;
    hold_n  = hold;
    unique case (state)
      SCR_MENU: begin
        if (do_sel) begin
          if (icon == MENU_PLAY) begin
            state_n = SCR_GAME;
            p1_n    = '0;
            p2_n    = '0;
            serve_n = 1'b1;
          end else if (icon == MENU_OPTIONS) begin
            state_n = SCR_OPTIONS;
            icon_n  = OPT_SPEED;
          end else begin
            state_n = SCR_CREDITS;
            icon_n  = '0;
          end
        end else if (do_up) begin
          if (icon != MENU_PLAY) icon_n = icon - 1'b1;
        end else if (do_down) begin
          if (icon != MENU_CREDITS) icon_n = icon + 1'b1;
        end
      end
      SCR_OPTIONS: begin
        if (do_back || (do_sel && icon == OPT_BACK)) begin
          state_n = SCR_MENU;
          icon_n  = MENU_OPTIONS;
        end else if (do_sel) begin
          speed_n = speed + 1'b1;
        end else if (do_up) begin
          icon_n = OPT_SPEED;
        end else if (do_down) begin
          icon_n = OPT_BACK;
        end
      end
      SCR_CREDITS: begin
        if (do_sel || do_back) begin
          state_n = SCR_MENU;
          icon_n  = MENU_CREDITS;
        end
      end
      SCR_GAME: begin
        if (do_back) begin
          state_n = SCR_MENU;
          icon_n  = MENU_PLAY;
          p1_n    = '0;
          p2_n    = '0;
        end else if (point_left || point_right) begin
          p1_n = p1_sum;
          p2_n = p2_sum;
          hold_n = '0;
          if (p1_sum == WIN)      state_n = SCR_P1WIN;
          else if (p2_sum == WIN) state_n = SCR_P2WIN;
          else                    serve_n = 1'b1;
        end
      end
      SCR_P1WIN, SCR_P2WIN: begin
        if (do_sel || do_back || hold == HOLD_LAST) begin
          state_n = SCR_MENU;
          icon_n  = MENU_PLAY;
        end else begin
          hold_n = hold + 1'b1;
        end
      end
      default: begin
        state_n = SCR_MENU;
        icon_n  = MENU_PLAY;
      end
    endcase
  end

  assign screen_mode      = state;
  assign icon_highlighter = icon;
  assign speed_selector   = speed;
  assign score            = {p1, p2};
  assign game_active      = (state == SCR_GAME);

endmodule

// File: tb/tb_screen_controller.sv
// Bench for screen_controller: directed scenario plus randomized buttons and
// points, checked every cycle against a behavioural model of the screen rules.
module tb_screen_controller;

  localparam int D = 4;
  localparam int W = 3;
  localparam int H = 50;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_select, btn_back;
  logic       point_left, point_right;
  logic [2:0] screen_mode;
  logic [1:0] icon_highlighter;
  logic [1:0] speed_selector;
  logic [7:0] score;
  logic       game_active;
  logic       serve;

  screen_controller #(
    .DEBOUNCE_CYCLES(D),
    .WIN_SCORE      (W),
    .WIN_HOLD_CYCLES(H)
  ) dut (
    .pclk            (pclk),
    .rst_n           (rst_n),
    .btn_up          (btn_up),
    .btn_down        (btn_down),
    .btn_select      (btn_select),
    .btn_back        (btn_back),
    .point_left      (point_left),
    .point_right     (point_right),
    .screen_mode     (screen_mode),
    .icon_highlighter(icon_highlighter),
    .speed_selector  (speed_selector),
    .score           (score),
    .game_active     (game_active),
    .serve           (serve)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model; screens use the numeric mode codes 0..5.
  int  m_scr, m_icon, m_speed, m_p1, m_p2, m_serve;
  int  cyc, m_entry;
  bit  m_raw[4];
  bit  m_last[4];
  int  m_run[4];
  bit  m_lvl[4];
  bit  m_press[4];
  int  act;

  always @(posedge pclk) begin
    cyc++;
    // button index order is also the priority order: select, back, up, down
    m_raw = '{btn_select, btn_back, btn_up, btn_down};
    if (!rst_n) begin
      m_scr = 0; m_icon = 0; m_speed = 1; m_p1 = 0; m_p2 = 0; m_serve = 0;
      for (int i = 0; i < 4; i++) begin
        m_last[i] = 0; m_run[i] = 1; m_lvl[i] = 0; m_press[i] = 0;
      end
    end else begin
      act = -1;
      for (int i = 3; i >= 0; i--) if (m_press[i]) act = i;
      m_serve = 0;
      case (m_scr)
        0: begin
          if (act == 0) begin
            if (m_icon == 0) begin m_scr = 1; m_p1 = 0; m_p2 = 0; m_serve = 1; end
            else if (m_icon == 1) begin m_scr = 3; m_icon = 0; end
            else begin m_scr = 2; m_icon = 0; end
          end else if (act == 2) m_icon = (m_icon > 0) ? m_icon - 1 : 0;
          else if (act == 3)     m_icon = (m_icon < 2) ? m_icon + 1 : 2;
        end
        1: begin
          if (act == 1) begin
            m_scr = 0; m_icon = 0; m_p1 = 0; m_p2 = 0;
          end else if (point_left || point_right) begin
            m_p1 += int'(point_left);
            m_p2 += int'(point_right);
            if (m_p1 == W) begin m_scr = 4; m_entry = cyc; end
            else if (m_p2 == W) begin m_scr = 5; m_entry = cyc; end
            else m_serve = 1;
          end
        end
        2: if (act == 0 || act == 1) begin m_scr = 0; m_icon = 2; end
        3: begin
          if (act == 1 || (act == 0 && m_icon == 1)) begin m_scr = 0; m_icon = 1; end
          else if (act == 0) m_speed = (m_speed + 1) % 4;
          else if (act == 2) m_icon = 0;
          else if (act == 3) m_icon = 1;
        end
        default: if (act == 0 || act == 1 || cyc - m_entry == H) begin m_scr = 0; m_icon = 0; end
      endcase
      // a level is accepted once D+1 consecutive samples agree
      for (int i = 0; i < 4; i++) begin
        m_press[i] = 0;
        if (m_raw[i] == m_last[i]) m_run[i]++;
        else m_run[i] = 1;
        m_last[i] = m_raw[i];
        if (m_run[i] >= D + 1 && m_lvl[i] != m_raw[i]) begin
          m_lvl[i]   = m_raw[i];
          m_press[i] = m_raw[i];
        end
      end
    end
  end

  always @(negedge pclk) begin
    if (check_en) begin
      check("mode",   int'(screen_mode),      m_scr);
      check("icon",   int'(icon_highlighter), m_icon);
      check("speed",  int'(speed_selector),   m_speed);
      check("score",  int'(score),            m_p1 * 16 + m_p2);
      check("active", int'(game_active),      int'(m_scr == 1));
      check("serve",  int'(serve),            m_serve);
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_select = v;
      1: btn_back   = v;
      2: btn_up     = v;
      default: btn_down = v;
    endcase
  endtask

  // Called and returns #1 after a posedge.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (8) @(posedge pclk);
    #1 set_btn(b, 1'b0);
    repeat (8) @(posedge pclk);
    #1;
  endtask

  task automatic point(input logic l, input logic r, input int exp_serve);
    point_left = l; point_right = r;
    @(posedge pclk);
    #1 point_left = 1'b0; point_right = 1'b0;
    @(negedge pclk);
    check("serve_after_point", int'(serve), exp_serve);
    @(posedge pclk);
    #1;
  endtask

  task automatic enter_game();
    int found;
    found = 0;
    btn_select = 1'b1;
    for (int n = 0; n < 15 && found == 0; n++) begin
      @(negedge pclk);
      if (screen_mode == 3'b001) found = 1;
    end
    check("game_entered", found, 1);
    check("entry_serve", int'(serve), 1);
    check("entry_score", int'(score), 8'h00);
    @(negedge pclk);
    check("entry_serve_once", int'(serve), 0);
    @(posedge pclk);
    #1 btn_select = 1'b0;
    repeat (8) @(posedge pclk);
    #1;
  endtask

  initial begin
    int n_hold;
    rst_n = 1'b0;
    {btn_up, btn_down, btn_select, btn_back, point_left, point_right} = '0;
    @(posedge pclk);
    check_en = 1;
    @(posedge pclk);
    #1 rst_n = 1'b1;
    @(negedge pclk);
    check("rst_mode",  int'(screen_mode), 0);
    check("rst_icon",  int'(icon_highlighter), 0);
    check("rst_speed", int'(speed_selector), 1);
    check("rst_score", int'(score), 8'h00);
    check("rst_serve", int'(serve), 0);
    @(posedge pclk);
    #1;

    // bounce, then a clean hold: one step only
    for (int i = 0; i < 10; i++) begin
      btn_down = ~btn_down;
      @(posedge pclk);
      #1;
    end
    btn_down = 1'b1;
    repeat (8) @(posedge pclk);
    #1 btn_down = 1'b0;
    repeat (8) @(posedge pclk);
    #1;
    check("bounce_icon", int'(icon_highlighter), 1);

    press(2);
    check("up_icon", int'(icon_highlighter), 0);
    press(3);
    press(0);
    check("opt_mode", int'(screen_mode), 3'b011);
    check("opt_icon", int'(icon_highlighter), 0);
    press(0); check("speed_a", int'(speed_selector), 2);
    press(0); check("speed_b", int'(speed_selector), 3);
    press(0); check("speed_c", int'(speed_selector), 0);
    press(0); check("speed_d", int'(speed_selector), 1);
    press(1);
    check("back_mode", int'(screen_mode), 3'b000);
    check("back_icon", int'(icon_highlighter), 1);

    press(2);
    enter_game();
    check("game_active", int'(game_active), 1);
    point(1'b1, 1'b0, 1);
    point(1'b1, 1'b0, 1);
    point(1'b0, 1'b1, 1);
    check("score_21", int'(score), 8'h21);
    point(1'b0, 1'b1, 1);
    point(1'b1, 1'b1, 0);
    check("score_33", int'(score), 8'h33);
    check("p1win_mode", int'(screen_mode), 3'b100);

    press(1);
    check("win_back_mode", int'(screen_mode), 3'b000);
    check("win_held_score", int'(score), 8'h33);
    enter_game();
    point(1'b0, 1'b1, 1);
    point(1'b0, 1'b1, 1);
    point(1'b0, 1'b1, 0);
    check("p2win_mode", int'(screen_mode), 3'b101);
    check("p2win_score", int'(score), 8'h03);
    n_hold = 0;
    for (int n = 1; n <= 60 && n_hold == 0; n++) begin
      @(negedge pclk);
      if (screen_mode == 3'b000) n_hold = n;
    end
    check("hold_cycles", n_hold, H);
    check("hold_icon", int'(icon_highlighter), 0);
    check("hold_score", int'(score), 8'h03);
    @(posedge pclk);
    #1;
    enter_game();

    // randomized traffic, including occasional resets
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 9) == 0) btn_select = ~btn_select;
      if ($urandom_range(0, 11) == 0) btn_back = ~btn_back;
      if ($urandom_range(0, 9) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 9) == 0) btn_down = ~btn_down;
      point_left  = ($urandom_range(0, 5) == 0);
      point_right = ($urandom_range(0, 5) == 0);
      rst_n       = ($urandom_range(0, 799) != 0);
      @(posedge pclk);
      #1;
    end
    rst_n = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/screen_controller.md
Name: screen_controller

Overview:
- Top-level game/menu sequencer that sits directly upstream of the VGA output stage.
- Turns four pushbutton levels and ball-logic point pulses into screen_mode, icon_highlighter, speed_selector and score, all registered on pclk.
- Also tells the ball/paddle logic when play is live and when to re-serve.
- Contains per-button debounce and edge detection, the screen state machine and the score counters.

Parameters:
- DEBOUNCE_CYCLES, 650000, cycles a raw button level must stay stable before it is accepted (10 ms at 65 MHz).
- WIN_SCORE, 9, points that end a match (1..15).
- WIN_HOLD_CYCLES, 325000000, winner-screen timeout in cycles before auto-return to MENU (5 s).

Ports:
- pclk  in  1  65 MHz pixel/system clock.
- rst_n  in  1  synchronous reset, active-low.
- btn_up  in  1  raw button level, already synchronised to pclk.
- btn_down  in  1  raw button level, already synchronised to pclk.
- btn_select  in  1  raw button level, already synchronised to pclk.
- btn_back  in  1  raw button level, already synchronised to pclk.
- point_left  in  1  one-cycle pulse: left player (P1) scored.
- point_right  in  1  one-cycle pulse: right player (P2) scored.
- screen_mode  out  3  000 MENU, 001 GAME, 010 CREDITS, 011 OPTIONS, 100 P1 WINS, 101 P2 WINS.
- icon_highlighter  out  2  highlighted item on the current screen.
- speed_selector  out  2  ball speed setting, 0..3.
- score  out  8  [7:4] P1 points, [3:0] P2 points, binary.
- game_active  out  1  high while screen_mode is GAME.
- serve  out  1  one-cycle pulse: ball logic must re-centre the ball.

Behaviour:
- One clock (pclk). Reset is synchronous, active-low: when rst_n is low at a pclk edge, all registers clear.
- Reset values: screen_mode=000, icon_highlighter=0, speed_selector=1, score=0, game_active=0, serve=0, debounce state cleared (all buttons released).
- Reset mid-game discards the score and returns to MENU on the next edge.
- Debounce: a counter per button reloads on any change of the raw level. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the raw value.
- Press pulse: a rising edge of the debounced level gives a one-cycle press pulse. Release produces nothing. A held button produces exactly one pulse.
- Latency: the FSM samples press pulses on the same edge that they are high, so the output change is visible on the following cycle.
- Simultaneous presses: only one acts, priority select > back > up > down. The others are discarded.
- MENU: items 0 Play, 1 Options, 2 Credits.
  - up: icon decrements, saturating at 0. down: icon increments, saturating at 2.
  - select: item 0 goes to GAME; item 1 goes to OPTIONS with icon 0; item 2 goes to CREDITS. back is ignored.
- Entering GAME: score is cleared and serve pulses for one cycle.
- OPTIONS: items 0 Speed, 1 Back.
  - up/down move the icon, saturating 0..1.
  - select on Speed: speed_selector increments with wrap 3->0.
  - select on Back, or back anywhere: go to MENU with icon 1.
- CREDITS: select or back goes to MENU with icon 2.
- GAME:
  - game_active=1.
  - point_left increments P1; point_right increments P2.
  - Both pulses in the same cycle: both increment.
  - After each point without a win: serve pulses on the next cycle.
  - When the updated P1 count equals WIN_SCORE: go to P1 WINS. Otherwise, when the updated P2 count equals WIN_SCORE: go to P2 WINS. P1 wins a simultaneous reach.
  - back: go to MENU with icon 0 and clear the score. up/down/select are ignored (paddles use them elsewhere).
- P1 WINS / P2 WINS:
  - Score is frozen; point pulses are ignored.
  - The hold counter is cleared on entry.
  - select, back, or the counter reaching WIN_HOLD_CYCLES-1: go to MENU with icon 0. Score stays displayed until the next GAME entry.
- point_* pulses are ignored outside GAME.
- Score nibbles never exceed WIN_SCORE.
- icon_highlighter is 0 in GAME, CREDITS and the winner states.
- Encodings 110 and 111 are unreachable; if entered, return to MENU on the next edge.

Decomposition:
- Shared package pong_pkg holds:
  - the screen_mode encodings (SCR_MENU, SCR_GAME, SCR_CREDITS, SCR_OPTIONS, SCR_P1WIN, SCR_P2WIN),
  - the menu/options item indices,
  - the speed default (1).
- One sub-module, button_debounce: raw level in, debounced level plus press pulse out, parameter DEBOUNCE_CYCLES. Instantiated four times.

Test Plan (bench uses DEBOUNCE_CYCLES=4, WIN_SCORE=3, WIN_HOLD_CYCLES=50):
- rst_n low 2 cycles -> screen_mode=000, icon=0, speed=1, score=8'h00, serve=0.
- btn_down toggled 1/0 every cycle for 10 cycles, then held high 8 cycles -> icon moves 0->1 exactly once.
- From MENU: down, select -> screen_mode=011. Then select 4 times -> speed 1->2->3->0->1. Then back -> screen_mode=000, icon=1.
- From MENU icon 0: select -> screen_mode=001, serve pulse for 1 cycle. Then point_left x2 and point_right x1 -> score=8'h21, serve after each point.
- GAME at score 8'h22: point_left and point_right in the same cycle -> score=8'h33, screen_mode=100.
- In P2 WINS with no buttons -> MENU exactly 50 cycles after entry, icon=0, score held. Then select -> GAME, score=8'h00.
